// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and restoring divide with a HI/LO result pair.
// Optional zero-operand early-out when MULDIV_EARLY_OUT_EN is defined.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  typedef enum logic [2:0] {
    IDLE, PREP, RUN, FIX, DONE
  } state_t;

  state_t state, state_nxt;

  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_r, b_r, m_r;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               sgn_q, sgn_r;
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic               dz_r;

  logic               is_div, sgn_op, take, skip, b_zero;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, rem_sh, diff;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt, prod;
  logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;

  assign is_div = op_r[1];
  assign sgn_op = ~op_r[0];
  assign b_zero = (b_r == '0);
  assign take   = start & ~cancel & ((state == IDLE) | (state == DONE));

`ifdef MULDIV_EARLY_OUT_EN
  assign skip = is_div ? b_zero : ((a_r == '0) | b_zero);
`else
  assign skip = 1'b0;
`endif

  assign abs_a = (sgn_op & a_r[WIDTH-1]) ? -a_r : a_r;
  assign abs_b = (sgn_op & b_r[WIDTH-1]) ? -b_r : b_r;

  // multiplier sits in the low half and shifts out as the product shifts in
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + (acc[0] ? {1'b0, m_r} : '0);
  assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};

  assign rem_sh  = acc[2*WIDTH-1:WIDTH-1];
  assign diff    = rem_sh - {1'b0, m_r};
  assign div_nxt = diff[WIDTH]
                 ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                 : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign prod = sgn_q ? -acc : acc;
  assign quo  = sgn_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = sgn_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_comb begin
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (is_div) begin
      fix_hi = b_zero ? a_r : rem;
      fix_lo = b_zero ? '1 : quo;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cancel) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (start) state_nxt = PREP;
        PREP: state_nxt = skip ? FIX : RUN;
        RUN:  if (cnt == CNT_W'(WIDTH-1)) state_nxt = FIX;
        FIX:  state_nxt = DONE;
        DONE: state_nxt = start ? PREP : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_r  <= '0;
      a_r   <= '0;
      b_r   <= '0;
      m_r   <= '0;
      acc   <= '0;
      cnt   <= '0;
      sgn_q <= 1'b0;
      sgn_r <= 1'b0;
      hi_r  <= '0;
      lo_r  <= '0;
      dz_r  <= 1'b0;
    end else begin
      dz_r <= 1'b0;
      if (take) begin
        op_r <= op;
        a_r  <= a;
        b_r  <= b;
      end
      unique case (state)
        PREP: begin
          sgn_q <= sgn_op & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
          sgn_r <= sgn_op & is_div & a_r[WIDTH-1];
          cnt   <= '0;
          m_r   <= is_div ? abs_b : abs_a;
          acc   <= skip ? '0
                 : {{WIDTH{1'b0}}, (is_div ? abs_a : abs_b)};
        end
        RUN: begin
          acc <= is_div ? div_nxt : mul_nxt;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          if (!cancel) begin
            hi_r <= fix_hi;
            lo_r <= fix_lo;
            dz_r <= is_div & b_zero;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state == PREP) | (state == RUN) | (state == FIX);
  assign done        = (state == DONE);
  assign hi          = hi_r;
  assign lo          = lo_r;
  assign div_by_zero = dz_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: reference model results queued at issue,
// compared (value and latency) when done pulses.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cancel = 1'b0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .a(a), .b(b), .cancel(cancel), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           stamp;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int busy_run = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o,
                                 input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    exp_t e;
    logic [63:0] p;
    int signed sx, sy;
    sx = x;
    sy = y;
    e.dz = 1'b0;
    e.stamp = 0;
    e.hi = '0;
    e.lo = '0;
    case (o)
      2'd0: begin
        p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        {e.hi, e.lo} = p;
      end
      2'd1: begin
        p = {32'b0, x} * {32'b0, y};
        {e.hi, e.lo} = p;
      end
      2'd2: begin
        if (y == 0) begin
          e.dz = 1'b1; e.lo = '1; e.hi = x;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000; e.hi = '0;
        end else begin
          e.lo = sx / sy; e.hi = sx % sy;
        end
      end
      default: begin
        if (y == 0) begin
          e.dz = 1'b1; e.lo = '1; e.hi = x;
        end else begin
          e.lo = x / y; e.hi = x % y;
        end
      end
    endcase
    return e;
  endfunction

  // monitor: scoreboard pop, latency, busy width, div_by_zero outside done
  always @(negedge clk) begin
    if (reset_n) begin
      if (done) begin
        if (q.size() == 0) begin
          check("spurious_done", done, 1'b0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("hi", hi, e.hi);
          check("lo", lo, e.lo);
          check("dz", div_by_zero, e.dz);
          check("latency", cyc - e.stamp, LAT);
          check("busy_cycles", busy_run, LAT);
          last_hi = e.hi;
          last_lo = e.lo;
        end
      end else begin
        check("dz_no_done", div_by_zero, 1'b0);
      end
    end
    busy_run = busy ? busy_run + 1 : 0;
  end

  // called at a negedge; the following posedge samples start
  task automatic drive(input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input bit expect_done);
    exp_t e;
    start = 1'b1; op = o; a = x; b = y;
    if (expect_done) begin
      e = model(o, x, y);
      e.stamp = cyc + 1;
      q.push_back(e);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y);
    @(negedge clk);
    drive(o, x, y, 1'b1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 200; k++) begin
      if (done) break;
      @(negedge clk);
    end
    if (!done) check("done_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    check("rst_dz", div_by_zero, 1'b0);
    reset_n = 1'b1;

    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done();

    issue(2'd0, 32'hFFFF_FFFD, 32'd7);
    wait_done();
    drive(2'd3, 32'd7, 32'd2, 1'b1);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", busy, 1'b1);
    wait_done();

    issue(2'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done();
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done();
    issue(2'd2, 32'h1234_5678, 32'd0);
    wait_done();
    issue(2'd3, 32'hDEAD_BEEF, 32'd0);
    wait_done();
    issue(2'd2, 32'd100, 32'hFFFF_FFF9);
    wait_done();

    for (int i = 0; i < 8; i++) begin
      issue(2'(i % 4), $urandom, (i == 5) ? 32'd3 : $urandom);
      wait_done();
    end

    // start while busy is ignored: result and latency of the running op hold
    issue(2'd1, 32'd9, 32'd9);
    repeat (5) @(negedge clk);
    drive(2'd3, 32'd1, 32'd1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // cancel mid-op, with a start while busy
    @(negedge clk);
    drive(2'd1, 32'd5, 32'd6, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    drive(2'd1, 32'd7, 32'd7, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", busy, 1'b0);
    check("cancel_hi", hi, last_hi);
    check("cancel_lo", lo, last_lo);
    repeat (50) @(negedge clk);
    check("cancel_idle", busy, 1'b0);

    // asynchronous reset mid-RUN
    @(negedge clk);
    drive(2'd1, 32'hFFFF_0000, 32'h0001_0001, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_hi", hi, '0);
    check("arst_lo", lo, '0);
    @(negedge clk);
    reset_n = 1'b1;
    issue(2'd1, 32'd3, 32'd4);
    wait_done();
    check("mul3x4_lo", lo, 32'd12);

    repeat (5) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
